pm_noc_tx_arbiter: RTL and testbench
====================================

// Module: pm_noc_tx_arbiter
// PURPOSE
//  Shares the PM's single outbound NoC packet path between NUM_REQ requesters (e.g. core DTU port, debug, UART bridge).
//  Round-robin, packet-locked arbitration: a granted requester owns the path until its last beat is accepted.
//  Sits in the PM clock domain in front of the async NoC output FIFO writer.
//  One output register stage; a lock watchdog releases a stalled owner.
// PARAMETERS
//  NUM_REQ       3                           number of requesters, 2..8
//  PKT_W         NOC_ASYNC_FIFO_PACKET_SIZE  width of one packet beat
//  LOCK_TIMEOUT  1024                        idle cycles an owner may hold the lock without a beat; 0 = watchdog off
// PORTS
//  clk_pm_i       in   1              PM clock
//  reset_pm_i     in   1              synchronous reset, active-high
//  req_valid_i    in   NUM_REQ        per-requester beat valid
//  req_data_i     in   NUM_REQ*PKT_W  beat data; requester k at [k*PKT_W +: PKT_W]
//  req_last_i     in   NUM_REQ        final beat of packet
//  req_ready_o    out  NUM_REQ        beat accepted when valid&ready
//  out_valid_o    out  1              output beat valid (registered)
//  out_data_o     out  PKT_W          output beat data (registered)
//  out_last_o     out  1              output final beat (registered)
//  out_ready_i    in   1              downstream accepts beat
//  grant_o        out  NUM_REQ        one-hot current owner; 0 when IDLE
//  busy_o         out  1              1 while LOCKED
//  timeout_err_o  out  1              sticky: watchdog fired
//  err_clear_i    in   1              clears timeout_err_o
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, wdog=0; all outputs 0 (including req_ready_o and out_*); the output register is discarded.
//  Reset mid-packet: the partial packet is dropped. No out_last_o is generated for it.
//  FSM IDLE:
//   - If any req_valid_i is set, pick the first valid index scanning upward from rr_ptr with wrap.
//   - Next cycle: LOCKED, owner = that index, grant_o = onehot(owner), wdog=0.
//   - req_ready_o is all-0 in IDLE. This gives one cycle of arbitration latency, so single-beat packets see 1 bubble.
//  FSM LOCKED:
//   - req_ready_o[owner] = ~out_valid_o | out_ready_i (combinational). All other req_ready_o bits are 0.
//   - Accepted beat: load out_data/out_last from req_data_i/req_last_i of the owner; out_valid_o=1 next cycle.
//   - Accepted beat with req_last_i=1: next state IDLE, rr_ptr = (owner+1) mod NUM_REQ.
//   - Output reg: out_valid_o clears on out_ready_i & out_valid_o unless reloaded in the same cycle.
//   - Back-to-back: 1 beat/cycle while out_ready_i=1.
//  Watchdog (LOCK_TIMEOUT>0):
//   - wdog increments each LOCKED cycle with no owner beat accepted; it clears on an accepted beat.
//   - wdog stalls (does not count) while out_valid_o & ~out_ready_i. Downstream backpressure is not the owner's fault.
//   - When wdog reaches LOCK_TIMEOUT-1 and another cycle passes with no beat: force IDLE, rr_ptr=owner+1, timeout_err_o=1.
//   - A beat already in the output register still drains. Downstream sees a truncated packet.
//  timeout_err_o: set has priority over err_clear_i in the same cycle.
//  Arbitration skips non-valid requesters. Only the owner's valid matters while LOCKED; valid may drop between beats.
//  rr_ptr arithmetic: wraps at NUM_REQ, which need not be a power of 2.
//  Owner deasserting req_valid_i indefinitely is resolved only by the watchdog. With LOCK_TIMEOUT=0 it holds forever.
// TESTING
//  T1 single requester:
//   - Stimulus: req0 sends a 3-beat packet A0,A1,A2 (last on A2); out_ready=1.
//   - Expected: grant_o=001 at cycle 1; out beats at cycles 2,3,4; last on A2; IDLE at cycle 4; rr_ptr=1.
//  T2 fairness:
//   - Stimulus: all 3 requesters continuously valid with 1-beat packets.
//   - Expected: grant order 0,1,2,0,1,2...; each output beat is followed by one bubble cycle.
//  T3 lock held:
//   - Stimulus: req1 sends a 4-beat packet; req0 asserts valid mid-packet.
//   - Expected: req0 waits; req1 beats are contiguous on the output with no interleave; req0 is granted only after req1's last beat.
//  T4 backpressure:
//   - Stimulus: out_ready=0 for 5 cycles during a packet.
//   - Expected: out_data holds stable; req_ready_o[owner]=0; no beat lost or duplicated; wdog does not advance.
//  T5 watchdog:
//   - Stimulus: LOCK_TIMEOUT=8; owner sends 1 non-last beat, then drops valid.
//   - Expected: 8 cycles after the beat, state returns to IDLE and timeout_err_o=1.
//   - Stimulus: assert err_clear_i. Expected: timeout_err_o=0.
//   - Stimulus: a new timeout and err_clear_i in the same cycle. Expected: timeout_err_o stays 1.
//  T6 reset mid-packet:
//   - Stimulus: assert reset_pm_i during beat 2 of 4.
//   - Expected: next cycle all outputs are 0 and grant_o=0; after release, arbitration restarts from req0.

Source files
------------

// File: rtl/pm_noc_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the PM outbound NoC packet path.
// Registered output stage; a lock watchdog releases an owner that stops sending beats.
module pm_noc_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int PKT_W        = 64,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                     clk_pm_i,
    input  logic                     reset_pm_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*PKT_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     out_valid_o,
    output logic [PKT_W-1:0]         out_data_o,
    output logic                     out_last_o,
    input  logic                     out_ready_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic                     timeout_err_o,
    input  logic                     err_clear_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   owner, owner_nx, rr_ptr, rr_nx, pick_idx, owner_inc;
    logic               pick_valid;
    logic [WD_W-1:0]    wdog, wdog_nx;
    logic               err_nx, room, beat, fire;
    logic [NUM_REQ-1:0] owner_oh;
    logic [PKT_W-1:0]   owner_data;
    logic [IDX_W:0]     cand;

    assign room      = ~out_valid_o | out_ready_i;
    assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
    assign beat      = (state == LOCKED) & req_valid_i[owner] & room;
    assign owner_inc = (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

    assign grant_o     = (state == LOCKED) ? owner_oh : '0;
    assign busy_o      = (state == LOCKED);
    assign req_ready_o = (state == LOCKED && room) ? owner_oh : '0;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!pick_valid && req_valid_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (owner == IDX_W'(i))
                owner_data = req_data_i[i*PKT_W +: PKT_W];
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        wdog_nx  = wdog;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx = LOCKED;
                    owner_nx = pick_idx;
                    wdog_nx  = '0;
                end
            end
            LOCKED: begin
                if (beat) begin
                    wdog_nx = '0;
                    if (req_last_i[owner]) begin
                        state_nx = IDLE;
                        rr_nx    = owner_inc;
                    end
                end else if (room && LOCK_TIMEOUT > 0) begin
                    // Downstream backpressure (no room) freezes the watchdog.
                    if (wdog == WD_W'(LOCK_TIMEOUT-1)) begin
                        fire     = 1'b1;
                        state_nx = IDLE;
                        rr_nx    = owner_inc;
                    end else begin
                        wdog_nx = wdog + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        err_nx = fire | (timeout_err_o & ~err_clear_i);
    end

    always_ff @(posedge clk_pm_i) begin
        if (reset_pm_i) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            wdog          <= '0;
            timeout_err_o <= 1'b0;
            out_valid_o   <= 1'b0;
            out_data_o    <= '0;
            out_last_o    <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            rr_ptr        <= rr_nx;
            wdog          <= wdog_nx;
            timeout_err_o <= err_nx;
            if (beat) begin
                out_valid_o <= 1'b1;
                out_data_o  <= owner_data;
                out_last_o  <= req_last_i[owner];
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pm_noc_tx_arbiter.sv
// Bench for pm_noc_tx_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pm_noc_tx_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           terr;
    logic           err_clear;

    int errors = 0;
    int checks = 0;

    pm_noc_tx_arbiter #(.NUM_REQ(N), .PKT_W(W), .LOCK_TIMEOUT(TO)) dut (
        .clk_pm_i(clk), .reset_pm_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready),
        .grant_o(grant), .busy_o(busy), .timeout_err_o(terr), .err_clear_i(err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [W-1:0] d, input logic l);
        req_valid[k]        = v;
        req_data[k*W +: W]  = d;
        req_last[k]         = l;
    endtask

    // Behavioural model: packet ownership, idle-cycle count since the last beat,
    // and a single-entry output register.
    int         m_locked, m_owner, m_ptr, m_idle;
    logic       m_ov, m_ol, m_err;
    logic [W-1:0] m_od;
    logic       m_room, m_beat, m_fired;

    initial begin
        m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
        m_ov = 0; m_ol = 0; m_od = '0; m_err = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
                m_ov = 0; m_ol = 0; m_od = '0; m_err = 0;
            end else begin
                m_room  = !m_ov || out_ready;
                m_beat  = (m_locked != 0) && req_valid[m_owner] && m_room;
                m_fired = 0;
                if (m_beat) begin
                    m_ov = 1;
                    m_od = req_data[m_owner*W +: W];
                    m_ol = req_last[m_owner];
                end else if (out_ready) begin
                    m_ov = 0;
                end
                if (m_locked == 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (m_locked == 0 && req_valid[(m_ptr + k) % N]) begin
                            m_locked = 1;
                            m_owner  = (m_ptr + k) % N;
                            m_idle   = 0;
                        end
                    end
                end else if (m_beat) begin
                    m_idle = 0;
                    if (req_last[m_owner]) begin
                        m_locked = 0;
                        m_ptr    = (m_owner + 1) % N;
                    end
                end else if (m_room) begin
                    m_idle++;
                    if (TO > 0 && m_idle >= TO) begin
                        m_fired  = 1;
                        m_locked = 0;
                        m_ptr    = (m_owner + 1) % N;
                    end
                end
                if (m_fired) m_err = 1;
                else if (err_clear) m_err = 0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("m_grant", 32'(grant), m_locked ? 32'd1 << m_owner : 32'd0);
            check("m_busy", 32'(busy), 32'(m_locked != 0));
            check("m_ready", 32'(req_ready),
                  (m_locked != 0 && (!m_ov || out_ready)) ? 32'd1 << m_owner : 32'd0);
            check("m_out_valid", 32'(out_valid), 32'(m_ov));
            check("m_timeout_err", 32'(terr), 32'(m_err));
            if (m_ov) begin
                check("m_out_data", 32'(out_data), 32'(m_od));
                check("m_out_last", 32'(out_last), 32'(m_ol));
            end
        end
    end

    initial begin
        rst = 1; req_valid = '0; req_data = '0; req_last = '0;
        out_ready = 1; err_clear = 0;
        repeat (3) nx();
        @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        nx();
        rst = 0;

        // single requester, 3-beat packet
        set_req(0, 1, 16'hA000, 0);
        @(negedge clk); check("t1_idle_grant", 32'(grant), 0);
        nx();
        @(negedge clk); check("t1_grant", 32'(grant), 3'b001);
        check("t1_ready", 32'(req_ready), 3'b001);
        nx(); set_req(0, 1, 16'hA001, 0);
        @(negedge clk); check("t1_b0", 32'(out_data), 16'hA000);
        check("t1_b0_last", 32'(out_last), 0);
        nx(); set_req(0, 1, 16'hA002, 1);
        @(negedge clk); check("t1_b1", 32'(out_data), 16'hA001);
        nx(); set_req(0, 0, 16'h0, 0);
        @(negedge clk); check("t1_b2", 32'(out_data), 16'hA002);
        check("t1_b2_last", 32'(out_last), 1);
        check("t1_idle", 32'(busy), 0);
        nx();

        // rr_ptr is now 1: req1 wins over req0, then watchdog on req1
        set_req(0, 1, 16'hB100, 0); set_req(1, 1, 16'hB000, 0);
        @(negedge clk); nx();
        set_req(0, 0, 16'h0, 0);
        @(negedge clk); check("t5_grant_rr", 32'(grant), 3'b010);
        nx(); set_req(1, 0, 16'h0, 0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("t5_still_locked", 32'(busy), 1);
            check("t5_no_err_yet", 32'(terr), 0);
            nx();
        end
        err_clear = 1;
        @(negedge clk);
        check("t5_released", 32'(busy), 0);
        check("t5_err_set", 32'(terr), 1);
        nx(); err_clear = 0; set_req(2, 1, 16'hC000, 0);
        @(negedge clk); check("t5_err_cleared", 32'(terr), 0);
        nx();
        @(negedge clk); check("t5_grant2", 32'(grant), 3'b100);
        nx(); set_req(2, 0, 16'h0, 0);
        for (int i = 0; i < TO; i++) begin
            if (i == TO-1) err_clear = 1;
            @(negedge clk);
            check("t5b_locked", 32'(busy), 1);
            nx();
        end
        @(negedge clk);
        check("t5_set_beats_clear", 32'(terr), 1);
        check("t5b_released", 32'(busy), 0);
        nx(); err_clear = 0;

        // one-beat packet from req0 moves rr_ptr to 1, then reset mid-packet from req1
        set_req(0, 1, 16'hE000, 1);
        @(negedge clk); check("t6_err_cleared", 32'(terr), 0);
        nx();
        @(negedge clk); check("t6_grant0", 32'(grant), 3'b001);
        nx(); set_req(0, 0, 16'h0, 0); set_req(1, 1, 16'hD000, 0);
        @(negedge clk); nx();
        @(negedge clk); check("t6_grant1", 32'(grant), 3'b010);
        nx(); set_req(1, 1, 16'hD001, 0); rst = 1;
        @(negedge clk); nx();
        rst = 0;
        set_req(0, 1, 16'hF000, 1); set_req(1, 1, 16'hF100, 1); set_req(2, 1, 16'hF200, 1);
        @(negedge clk);
        check("t6_grant_zero", 32'(grant), 0);
        check("t6_ready_zero", 32'(req_ready), 0);
        check("t6_ov_zero", 32'(out_valid), 0);
        check("t6_od_zero", 32'(out_data), 0);
        check("t6_ol_zero", 32'(out_last), 0);
        check("t6_busy_zero", 32'(busy), 0);
        nx();

        // all requesters valid with 1-beat packets: 0,1,2 with a bubble after each beat
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_grant", 32'(grant), (k % 2 == 0) ? 32'd1 << ((k / 2) % 3) : 32'd0);
            check("t2_bubble", 32'(out_valid), 32'(k % 2));
            nx();
        end
        req_valid = '0; req_last = '0;

        // randomized traffic, backpressure, rare resets and clears
        for (int c = 0; c < 3000; c++) begin
            nx();
            rst       = ($urandom_range(0, 499) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            err_clear = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < N; k++)
                set_req(k, $urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 3);
        end
        nx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
